// File: rtl/fp16_argmax_classifier.sv
`default_nettype none
// ============================================================================
// Module   : fp16_argmax_classifier
// Brief    : Serial FP16 argmax over NUM_CLASSES similarity scores; reports
//            the winning class index and score one cycle after the last score.
// Revision : 1.0 - initial release
// ============================================================================
module fp16_argmax_classifier #(
   parameter int NUM_CLASSES = 10,
   parameter int WIDTH       = 16,
   parameter int IDX_W       = $clog2(NUM_CLASSES)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             score_valid,
   input  logic [WIDTH-1:0] score,
   output logic             busy,
   output logic             result_valid,
   output logic [IDX_W-1:0] result_class,
   output logic [WIDTH-1:0] result_score,
   output logic             nan_flag
);

   localparam logic [WIDTH-1:0] c_neg_zero = 16'h8000;
   localparam logic [WIDTH-1:0] c_sign_bit = 16'h8000;
   localparam logic [WIDTH-1:0] c_qnan     = 16'h7E00;
   localparam logic [IDX_W-1:0] c_last_idx = IDX_W'(NUM_CLASSES - 1);

   typedef enum logic [0:0] {
      S_IDLE    = 1'b0,
      S_COLLECT = 1'b1
   } state_t;

   state_t           r_state;
   logic [IDX_W-1:0] r_cnt;
   logic [WIDTH-1:0] r_best;
   logic [IDX_W-1:0] r_best_idx;
   logic             r_best_valid;
   logic             r_nan;
   logic             r_result_valid;
   logic [IDX_W-1:0] r_result_class;
   logic [WIDTH-1:0] r_result_score;

   logic             w_is_nan;
   logic [WIDTH-1:0] w_canon;
   logic [WIDTH-1:0] w_key;
   logic [WIDTH-1:0] w_best_key;
   logic             w_take;
   logic             w_last;
   logic             w_fin_valid;
   logic [WIDTH-1:0] w_fin_score;
   logic [IDX_W-1:0] w_fin_idx;

   // Monotonic key: negatives are bit-inverted, positives get the sign bit set,
   // so an unsigned compare matches FP ordering (with -0 folded to +0 first).
   assign w_is_nan    = (score[14:10] == 5'h1F) && (score[9:0] != 10'd0);
   assign w_canon     = (score == c_neg_zero) ? '0 : score;
   assign w_key       = w_canon[WIDTH-1] ? ~w_canon : (w_canon ^ c_sign_bit);
   assign w_best_key  = r_best[WIDTH-1] ? ~r_best : (r_best ^ c_sign_bit);
   assign w_take      = !w_is_nan && (!r_best_valid || (w_key > w_best_key));
   assign w_last      = (r_cnt == c_last_idx);
   assign w_fin_valid = r_best_valid || w_take;
   assign w_fin_score = w_take ? w_canon : r_best;
   assign w_fin_idx   = w_take ? r_cnt : r_best_idx;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state        <= S_IDLE;
         r_cnt          <= '0;
         r_best         <= '0;
         r_best_idx     <= '0;
         r_best_valid   <= 1'b0;
         r_nan          <= 1'b0;
         r_result_valid <= 1'b0;
         r_result_class <= '0;
         r_result_score <= '0;
      end else begin
         r_result_valid <= 1'b0;
         if (start) begin
            r_state      <= S_COLLECT;
            r_cnt        <= '0;
            r_best       <= '0;
            r_best_idx   <= '0;
            r_best_valid <= 1'b0;
            r_nan        <= 1'b0;
         end else begin
            case (r_state)
               S_IDLE: begin
                  r_state <= S_IDLE;
               end
               S_COLLECT: begin
                  if (score_valid) begin
                     if (w_is_nan) begin
                        r_nan <= 1'b1;
                     end
                     if (w_take) begin
                        r_best       <= w_canon;
                        r_best_idx   <= r_cnt;
                        r_best_valid <= 1'b1;
                     end
                     // The counter holds at the last index rather than wrapping.
                     if (w_last) begin
                        r_state        <= S_IDLE;
                        r_result_valid <= 1'b1;
                        r_result_class <= w_fin_valid ? w_fin_idx : '0;
                        r_result_score <= w_fin_valid ? w_fin_score : c_qnan;
                     end else begin
                        r_cnt <= r_cnt + IDX_W'(1);
                     end
                  end
               end
               default: begin
                  r_state <= S_IDLE;
               end
            endcase
         end
      end
   end

   assign busy         = (r_state == S_COLLECT);
   assign result_valid = r_result_valid;
   assign result_class = r_result_class;
   assign result_score = r_result_score;
   assign nan_flag     = r_nan;

endmodule
`default_nettype wire

// File: tb/tb_fp16_argmax_classifier.sv
`default_nettype none
// ============================================================================
// Module   : tb_fp16_argmax_classifier
// Brief    : Scoreboard bench for fp16_argmax_classifier with NUM_CLASSES=4.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fp16_argmax_classifier;

   localparam int NC = 4;

   logic        clk;
   logic        rst;
   logic        start;
   logic        score_valid;
   logic [15:0] score;
   logic        busy;
   logic        result_valid;
   logic [1:0]  result_class;
   logic [15:0] result_score;
   logic        nan_flag;

   typedef struct packed {
      logic [1:0]  cls;
      logic [15:0] sc;
      logic        nan;
   } exp_t;

   exp_t q[$];
   int   n_cmp = 0;
   int   n_err = 0;

   fp16_argmax_classifier #(
      .NUM_CLASSES(NC),
      .WIDTH      (16),
      .IDX_W      (2)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .start       (start),
      .score_valid (score_valid),
      .score       (score),
      .busy        (busy),
      .result_valid(result_valid),
      .result_class(result_class),
      .result_score(result_score),
      .nan_flag    (nan_flag)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Monitor: every result pulse must match the oldest outstanding expectation.
   always @(negedge clk) begin
      if (rst === 1'b1 && result_valid === 1'b1) begin
         if (q.size() == 0) begin
            check("unexpected_result_valid", 32'd1, 32'd0);
         end else begin
            exp_t e;
            e = q.pop_front();
            check("result_class", 32'(result_class), 32'(e.cls));
            check("result_score", 32'(result_score), 32'(e.sc));
            check("nan_flag", 32'(nan_flag), 32'(e.nan));
         end
      end
   end

   task automatic drive(input logic st, input logic v, input logic [15:0] s);
      start       = st;
      score_valid = v;
      score       = s;
      @(posedge clk);
      #1;
   endtask

   // The start cycle carries a large finite score that must be discarded.
   task automatic run_query(input logic [15:0] s0, input logic [15:0] s1,
                            input logic [15:0] s2, input logic [15:0] s3,
                            input logic [1:0] ecls, input logic [15:0] esc,
                            input logic enan, input bit gaps);
      logic [15:0] s[4];
      s[0] = s0; s[1] = s1; s[2] = s2; s[3] = s3;
      q.push_back('{cls: ecls, sc: esc, nan: enan});
      drive(1'b1, 1'b1, 16'h7BFF);
      for (int i = 0; i < 4; i++) begin
         if (gaps) begin
            int g;
            g = $urandom_range(0, 3);
            for (int k = 0; k < g; k++) drive(1'b0, 1'b0, 16'h7BFF);
         end
         drive(1'b0, 1'b1, s[i]);
      end
      drive(1'b0, 1'b0, 16'h0000);
      drive(1'b0, 1'b0, 16'h0000);
   endtask

   initial begin
      rst = 1'b0; start = 1'b0; score_valid = 1'b0; score = '0;
      repeat (3) @(posedge clk);
      #1;
      check("reset_busy", 32'(busy), 32'd0);
      check("reset_result_valid", 32'(result_valid), 32'd0);
      check("reset_result_class", 32'(result_class), 32'd0);
      check("reset_result_score", 32'(result_score), 32'd0);
      check("reset_nan_flag", 32'(nan_flag), 32'd0);
      rst = 1'b1;
      drive(1'b0, 1'b0, 16'h0000);

      run_query(16'h3C00, 16'h4000, 16'hC000, 16'h3800, 2'd1, 16'h4000, 1'b0, 1'b0);
      run_query(16'h4000, 16'h4000, 16'h3C00, 16'h4000, 2'd0, 16'h4000, 1'b0, 1'b0);
      run_query(16'h8000, 16'h0000, 16'hC000, 16'hBC00, 2'd0, 16'h0000, 1'b0, 1'b0);
      run_query(16'hC400, 16'hC000, 16'hC200, 16'hC800, 2'd1, 16'hC000, 1'b0, 1'b0);
      run_query(16'h3C00, 16'h7E00, 16'h7C00, 16'h4000, 2'd2, 16'h7C00, 1'b1, 1'b0);
      run_query(16'h7E00, 16'h7E00, 16'h7E00, 16'h7E00, 2'd0, 16'h7E00, 1'b1, 1'b0);

      // Restart mid-query: the abandoned partial query yields no result.
      drive(1'b1, 1'b0, 16'h0000);
      check("busy_after_start", 32'(busy), 32'd1);
      drive(1'b0, 1'b1, 16'h5000);
      drive(1'b0, 1'b1, 16'h3C00);
      run_query(16'h3C00, 16'h3800, 16'h3400, 16'h3000, 2'd0, 16'h3C00, 1'b0, 1'b0);
      check("busy_after_result", 32'(busy), 32'd0);

      run_query(16'h3C00, 16'h4000, 16'hC000, 16'h3800, 2'd1, 16'h4000, 1'b0, 1'b1);
      run_query(16'hC400, 16'hC000, 16'hC200, 16'hC800, 2'd1, 16'hC000, 1'b0, 1'b1);

      // Asynchronous reset mid-query, with a NaN already flagged.
      drive(1'b1, 1'b0, 16'h0000);
      drive(1'b0, 1'b1, 16'h7E00);
      drive(1'b0, 1'b1, 16'h4000);
      check("nan_flag_live", 32'(nan_flag), 32'd1);
      rst = 1'b0;
      #1;
      check("midrst_busy", 32'(busy), 32'd0);
      check("midrst_result_class", 32'(result_class), 32'd0);
      check("midrst_result_score", 32'(result_score), 32'd0);
      check("midrst_nan_flag", 32'(nan_flag), 32'd0);
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b1;
      for (int i = 0; i < 6; i++) drive(1'b0, 1'b1, 16'h4000);
      check("idle_busy", 32'(busy), 32'd0);
      check("idle_result_score", 32'(result_score), 32'd0);

      run_query(16'hBC00, 16'h3800, 16'h7C00, 16'hFC00, 2'd2, 16'h7C00, 1'b0, 1'b0);

      for (int i = 0; i < 50 && q.size() != 0; i++) @(posedge clk);
      if (q.size() != 0) check("outstanding_results", 32'(q.size()), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
`default_nettype wire
